// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : opcode encodings and operand width shared by decode and EXE ALU
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;

    // MIPS R-type funct field, plus spare code 0x0F for LUI
    localparam logic [5:0] ALU_OP_SLL   = 6'h00;
    localparam logic [5:0] ALU_OP_SRL   = 6'h02;
    localparam logic [5:0] ALU_OP_SRA   = 6'h03;
    localparam logic [5:0] ALU_OP_SLLV  = 6'h04;
    localparam logic [5:0] ALU_OP_SRLV  = 6'h06;
    localparam logic [5:0] ALU_OP_SRAV  = 6'h07;
    localparam logic [5:0] ALU_OP_LUI   = 6'h0F;
    localparam logic [5:0] ALU_OP_MFHI  = 6'h10;
    localparam logic [5:0] ALU_OP_MTHI  = 6'h11;
    localparam logic [5:0] ALU_OP_MFLO  = 6'h12;
    localparam logic [5:0] ALU_OP_MTLO  = 6'h13;
    localparam logic [5:0] ALU_OP_MULT  = 6'h18;
    localparam logic [5:0] ALU_OP_MULTU = 6'h19;
    localparam logic [5:0] ALU_OP_ADD   = 6'h20;
    localparam logic [5:0] ALU_OP_ADDU  = 6'h21;
    localparam logic [5:0] ALU_OP_SUB   = 6'h22;
    localparam logic [5:0] ALU_OP_SUBU  = 6'h23;
    localparam logic [5:0] ALU_OP_AND   = 6'h24;
    localparam logic [5:0] ALU_OP_OR    = 6'h25;
    localparam logic [5:0] ALU_OP_XOR   = 6'h26;
    localparam logic [5:0] ALU_OP_NOR   = 6'h27;
    localparam logic [5:0] ALU_OP_SLT   = 6'h2A;
    localparam logic [5:0] ALU_OP_SLTU  = 6'h2B;

    function automatic logic is_hilo_write(input logic [5:0] op);
        return (op == ALU_OP_MTHI) || (op == ALU_OP_MTLO) ||
               (op == ALU_OP_MULT) || (op == ALU_OP_MULTU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exe_alu_if.sv
// ---------------------------------------------------------------------------
// exe_alu_if : operand/opcode bundle into the EXE ALU and its result flags
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface exe_alu_if;

    logic [alu_pkg::ALU_WIDTH-1:0] i_ALU_srcA;
    logic [alu_pkg::ALU_WIDTH-1:0] i_ALU_srcB;
    logic [5:0]                    i_ALU_op;
    logic                          i_ALU_valid;
    logic [alu_pkg::ALU_WIDTH-1:0] o_ALU_aluOut;
    logic                          o_ALU_zero;
    logic                          o_ALU_overflow;

    modport master (
        output i_ALU_srcA, i_ALU_srcB, i_ALU_op, i_ALU_valid,
        input  o_ALU_aluOut, o_ALU_zero, o_ALU_overflow
    );

    modport slave (
        input  i_ALU_srcA, i_ALU_srcB, i_ALU_op, i_ALU_valid,
        output o_ALU_aluOut, o_ALU_zero, o_ALU_overflow
    );

endinterface

`default_nettype wire

// File: rtl/alu_hilo.sv
// ---------------------------------------------------------------------------
// alu_hilo : HI/LO register pair, single-cycle 32x32 multiplier, write decode
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_hilo
    import alu_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rstn,
    input  wire alu_word_t a_i,
    input  wire alu_word_t b_i,
    input  wire logic [5:0] op_i,
    input  wire logic      valid_i,
    output alu_word_t      hi_o,
    output alu_word_t      lo_o
);

    alu_word_t   hi_q, hi_d;
    alu_word_t   lo_q, lo_d;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // Operands widened to 64 bits so the truncated product is the full one
    assign w_prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign w_prod_u = {32'b0, a_i} * {32'b0, b_i};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (valid_i) begin
            case (op_i)
                ALU_OP_MTHI:  hi_d = a_i;
                ALU_OP_MTLO:  lo_d = a_i;
                ALU_OP_MULT:  {hi_d, lo_d} = w_prod_s;
                ALU_OP_MULTU: {hi_d, lo_d} = w_prod_u;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/exe_alu.sv
// ---------------------------------------------------------------------------
// exe_alu : combinational 32-bit EXE-stage ALU with optional HI/LO multiply
//           unit, built only when ALU_MULDIV_EN is defined
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exe_alu
    import alu_pkg::*;
(
    input  wire logic clk,
    input  wire logic rstn,
    exe_alu_if.slave  alu
);

    alu_word_t  w_a;
    alu_word_t  w_b;
    logic [5:0] w_op;
    logic [4:0] w_shamt;
    alu_word_t  w_sum;
    alu_word_t  w_diff;
    alu_word_t  w_sra;
    alu_word_t  w_result;
    logic       w_ovf;

    assign w_a     = alu.i_ALU_srcA;
    assign w_b     = alu.i_ALU_srcB;
    assign w_op    = alu.i_ALU_op;
    assign w_shamt = w_a[4:0];
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;
    assign w_sra   = $signed(w_b) >>> w_shamt;

`ifdef ALU_MULDIV_EN
    alu_word_t w_hi;
    alu_word_t w_lo;

    alu_hilo u_hilo (
        .clk     (clk),
        .rstn    (rstn),
        .a_i     (w_a),
        .b_i     (w_b),
        .op_i    (w_op),
        .valid_i (alu.i_ALU_valid),
        .hi_o    (w_hi),
        .lo_o    (w_lo)
    );
`else
    logic unused_muldiv;
    assign unused_muldiv = &{1'b0, clk, rstn, alu.i_ALU_valid};
`endif

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (w_op)
            ALU_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
            end
            ALU_OP_ADDU: w_result = w_sum;
            ALU_OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
            end
            ALU_OP_SUBU: w_result = w_diff;
            ALU_OP_AND:  w_result = w_a & w_b;
            ALU_OP_OR:   w_result = w_a | w_b;
            ALU_OP_XOR:  w_result = w_a ^ w_b;
            ALU_OP_NOR:  w_result = ~(w_a | w_b);
            ALU_OP_SLT:  w_result = {31'b0, $signed(w_a) < $signed(w_b)};
            ALU_OP_SLTU: w_result = {31'b0, w_a < w_b};
            ALU_OP_SLL, ALU_OP_SLLV: w_result = w_b << w_shamt;
            ALU_OP_SRL, ALU_OP_SRLV: w_result = w_b >> w_shamt;
            ALU_OP_SRA, ALU_OP_SRAV: w_result = w_sra;
            ALU_OP_LUI:  w_result = {w_b[15:0], 16'h0000};
`ifdef ALU_MULDIV_EN
            // Reads see the registered value: no bypass of a same-cycle write
            ALU_OP_MFHI: w_result = w_hi;
            ALU_OP_MFLO: w_result = w_lo;
`endif
            default: ;
        endcase
    end

    assign alu.o_ALU_aluOut   = w_result;
    assign alu.o_ALU_zero     = (w_result == '0);
    assign alu.o_ALU_overflow = w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_exe_alu.sv
// ---------------------------------------------------------------------------
// tb_exe_alu : scoreboard bench for exe_alu, directed cases plus random ops
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exe_alu;
    import alu_pkg::*;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    localparam longint MAX_S32 = 64'sd2147483647;
    localparam longint MIN_S32 = -64'sd2147483648;

    logic clk;
    logic rstn;
    exe_alu_if alu_if ();

    exe_alu dut (
        .clk  (clk),
        .rstn (rstn),
        .alu  (alu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb_q[$];
    event        sample_ev;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    // Reference: arithmetic on 64-bit integers, not bit-level flag logic
    function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic ov);
        longint sa, sb, t;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a % 32);
        t  = 0;
        r  = 32'h0;
        ov = 1'b0;
        case (op)
            ALU_OP_ADD:  begin t = sa + sb; r = t[31:0]; ov = (t > MAX_S32) || (t < MIN_S32); end
            ALU_OP_ADDU: r = a + b;
            ALU_OP_SUB:  begin t = sa - sb; r = t[31:0]; ov = (t > MAX_S32) || (t < MIN_S32); end
            ALU_OP_SUBU: r = a - b;
            ALU_OP_AND:  r = a & b;
            ALU_OP_OR:   r = a | b;
            ALU_OP_XOR:  r = a ^ b;
            ALU_OP_NOR:  r = ~(a | b);
            ALU_OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_OP_SLL, ALU_OP_SLLV: r = b << sh;
            ALU_OP_SRL, ALU_OP_SRLV: r = b >> sh;
            ALU_OP_SRA, ALU_OP_SRAV: begin t = sb >>> sh; r = t[31:0]; end
            ALU_OP_LUI:  r = b * 32'h10000;
`ifdef ALU_MULDIV_EN
            ALU_OP_MFHI: r = hi_m;
            ALU_OP_MFLO: r = lo_m;
`endif
            default: r = 32'h0;
        endcase
    endfunction

    task automatic check_now(input string nm);
        exp_t e;
        ref_alu(alu_if.i_ALU_op, alu_if.i_ALU_srcA, alu_if.i_ALU_srcB, e.res, e.ovf);
        e.nm   = nm;
        e.zero = (e.res == 32'h0);
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    // Drive one op after the edge, check it mid-cycle, then model the next edge
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic v, input string nm);
        longint      p;
        logic [63:0] pu;
        @(posedge clk);
        #1;
        alu_if.i_ALU_op    = op;
        alu_if.i_ALU_srcA  = a;
        alu_if.i_ALU_srcB  = b;
        alu_if.i_ALU_valid = v;
        #1;
        check_now(nm);
`ifdef ALU_MULDIV_EN
        if (v && rstn) begin
            case (op)
                ALU_OP_MTHI: hi_m = a;
                ALU_OP_MTLO: lo_m = a;
                ALU_OP_MULT: begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    {hi_m, lo_m} = p;
                end
                ALU_OP_MULTU: begin
                    pu = {32'h0, a} * {32'h0, b};
                    {hi_m, lo_m} = pu;
                end
                default: ;
            endcase
        end
`endif
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: output seen with no expectation queued");
            end else begin
                e = sb_q.pop_front();
                if (alu_if.o_ALU_aluOut !== e.res || alu_if.o_ALU_zero !== e.zero ||
                    alu_if.o_ALU_overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL %s: got out=%08h zero=%0b ovf=%0b, expected out=%08h zero=%0b ovf=%0b",
                             e.nm, alu_if.o_ALU_aluOut, alu_if.o_ALU_zero, alu_if.o_ALU_overflow,
                             e.res, e.zero, e.ovf);
                end
            end
        end
    end

    initial begin : driver
        logic [5:0] ops [23];
        logic [5:0] op;
        ops = '{ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLLV, ALU_OP_SRLV, ALU_OP_SRAV,
                ALU_OP_LUI, ALU_OP_MFHI, ALU_OP_MTHI, ALU_OP_MFLO, ALU_OP_MTLO, ALU_OP_MULT,
                ALU_OP_MULTU, ALU_OP_ADD, ALU_OP_ADDU, ALU_OP_SUB, ALU_OP_SUBU, ALU_OP_AND,
                ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOR, ALU_OP_SLT, ALU_OP_SLTU};
        rstn               = 1'b0;
        alu_if.i_ALU_op    = 6'h3F;
        alu_if.i_ALU_srcA  = 32'h0;
        alu_if.i_ALU_srcB  = 32'h0;
        alu_if.i_ALU_valid = 1'b0;

        // Reset state and combinational path while held in reset
        issue(ALU_OP_MFHI, 32'h1, 32'h2, 1'b1, "reset_mfhi");
        issue(ALU_OP_MFLO, 32'h1, 32'h2, 1'b1, "reset_mflo");
        issue(ALU_OP_ADDU, 32'h5, 32'h7, 1'b0, "reset_addu");
        @(negedge clk);
        rstn = 1'b1;

        issue(ALU_OP_ADD,  32'h7FFFFFFF, 32'h1, 1'b1, "add_ovf");
        issue(ALU_OP_ADDU, 32'h7FFFFFFF, 32'h1, 1'b1, "addu_no_ovf");
        issue(ALU_OP_SUB,  32'h5, 32'h5, 1'b1, "sub_zero");
        issue(ALU_OP_SUB,  32'h80000000, 32'h1, 1'b1, "sub_ovf");
        issue(ALU_OP_SLT,  32'hFFFFFFFF, 32'h1, 1'b1, "slt_signed");
        issue(ALU_OP_SLTU, 32'hFFFFFFFF, 32'h1, 1'b1, "sltu_unsigned");
        issue(ALU_OP_SRA,  32'h24, 32'h80000010, 1'b1, "sra");
        issue(ALU_OP_SRL,  32'h24, 32'h80000010, 1'b1, "srl");
        issue(ALU_OP_SLL,  32'h24, 32'h80000010, 1'b1, "sll");
        issue(ALU_OP_SRAV, 32'hFFFFFFFF, 32'h80000000, 1'b1, "srav_31");
        issue(ALU_OP_LUI,  32'h0, 32'h00001234, 1'b1, "lui");
        issue(6'h3F,       32'h12345678, 32'h9ABCDEF0, 1'b1, "undef_op");

        // HI/LO: no bypass, signed then unsigned product
        issue(ALU_OP_MFHI,  32'h0, 32'h0, 1'b1, "mfhi_before_mult");
        issue(ALU_OP_MULT,  32'hFFFFFFFE, 32'h3, 1'b1, "mult_result0");
        issue(ALU_OP_MFHI,  32'h0, 32'h0, 1'b1, "mfhi_after_mult");
        issue(ALU_OP_MFLO,  32'h0, 32'h0, 1'b1, "mflo_after_mult");
        issue(ALU_OP_MULTU, 32'hFFFFFFFE, 32'h3, 1'b1, "multu_result0");
        issue(ALU_OP_MFHI,  32'h0, 32'h0, 1'b1, "mfhi_after_multu");
        issue(ALU_OP_MFLO,  32'h0, 32'h0, 1'b1, "mflo_after_multu");

        // Stalled MTLO writes only on the valid edge
        for (int i = 0; i < 3; i++) issue(ALU_OP_MTLO, 32'hDEADBEEF, 32'h0, 1'b0, "mtlo_stalled");
        issue(ALU_OP_MFLO, 32'h0, 32'h0, 1'b1, "mflo_after_stall");
        issue(ALU_OP_MTLO, 32'hDEADBEEF, 32'h0, 1'b1, "mtlo_valid");
        issue(ALU_OP_MFLO, 32'h0, 32'h0, 1'b1, "mflo_after_mtlo");

        // Mid-cycle asynchronous reset clears LO at once; writes during reset are lost
        #2;
        rstn = 1'b0;
        hi_m = 32'h0;
        lo_m = 32'h0;
        #1;
        check_now("mflo_async_reset");
        issue(ALU_OP_MTLO, 32'hCAFEF00D, 32'h0, 1'b1, "mtlo_in_reset");
        issue(ALU_OP_MFLO, 32'h0, 32'h0, 1'b1, "mflo_in_reset");
        #3;
        rstn = 1'b1;
        issue(ALU_OP_MFLO, 32'h0, 32'h0, 1'b1, "mflo_after_reset");

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 22)];
            issue(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  ($urandom_range(0, 3) != 0), "random");
        end

        #20;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exe_alu.md
# exe_alu

Combinational 32-bit integer ALU for the EXE stage of the pipelined MIPS-style CPU, with a clocked HI/LO register pair for multiply results. Operands A and B arrive already muxed by the EXE stage. Shifts take the shift amount from A and the shifted value from B. Opcodes use the 6-bit MIPS R-type funct encoding plus one spare code for LUI.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  stage clock; HI/LO update on rising edge
- rstn  in  1  asynchronous, active-low reset
- i_ALU_srcA  in  32  operand A; bits [4:0] are the shift amount for shift ops
- i_ALU_srcB  in  32  operand B; the shifted value for shift ops
- i_ALU_op  in  6  operation code
- i_ALU_valid  in  1  qualifies HI/LO writes; 0 during stalls and bubbles
- o_ALU_aluOut  out  32  result (combinational)
- o_ALU_zero  out  1  (o_ALU_aluOut == 0)
- o_ALU_overflow  out  1  signed overflow, ADD/SUB only; otherwise 0

## Operation
- 0x20 ADD and 0x21 ADDU: A+B, mod 2^32.
- 0x22 SUB and 0x23 SUBU: A−B, mod 2^32.
- 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise operations.
- 0x2A SLT: signed A<B gives 1, else 0. 0x2B SLTU: the unsigned version.
- 0x00 SLL and 0x04 SLLV: B << A[4:0].
- 0x02 SRL and 0x06 SRLV: B >> A[4:0], logical.
- 0x03 SRA and 0x07 SRAV: B >>> A[4:0], arithmetic. A[31:5] is ignored.
- 0x0F LUI: {B[15:0], 16'h0}.
- 0x10 MFHI: result is HI. 0x12 MFLO: result is LO.
- 0x11 MTHI: HI←A on the edge. 0x13 MTLO: LO←A on the edge. Result is 0.
- 0x18 MULT: {HI,LO}←signed A×B on the edge. 0x19 MULTU: the unsigned product. Result is 0.
- Any other code: result is 0, overflow is 0, HI/LO unchanged.
- Overflow flag:
  - ADD: A[31]==B[31] and sum[31]!=A[31].
  - SUB: A[31]!=B[31] and diff[31]!=A[31].
  - The ALU never suppresses its own result. The pipeline decides what to do on an overflow trap.

## Timing
- o_ALU_aluOut, o_ALU_zero and o_ALU_overflow are purely combinational from the inputs and the current HI/LO. Latency is 0 cycles.
- HI/LO write on the rising clk only when i_ALU_valid=1 and op ∈ {MTHI, MTLO, MULT, MULTU}. A full 64-bit product is written in the same cycle, so there is no multi-cycle busy state.
- There is no bypass:
  - MFHI/MFLO in the same cycle as a write return the old value.
  - In the following cycle they return the new value.
- i_ALU_valid=0 blocks all HI/LO writes. A stalled MULT held for N cycles writes exactly once, on the edge where valid=1.
- Reset:
  - rstn low clears HI and LO to 0 immediately, without waiting for clk.
  - During reset, MFHI/MFLO read 0.
  - A write presented while rstn is low is lost.
  - Combinational outputs keep following the inputs during reset.

## Configuration
- ALU_MULDIV_EN defined: HI/LO registers and opcodes 0x10–0x13, 0x18, 0x19 behave as above.
- ALU_MULDIV_EN undefined:
  - No HI/LO storage and no multiplier is built.
  - Those opcodes fall into the "other code" case: result 0, no state.
  - clk, rstn and i_ALU_valid stay as ports and are unused.

## Structure
- Shared package alu_pkg holds the 6-bit opcode localparams (ALU_OP_ADD … ALU_OP_MULTU, ALU_OP_LUI) and the operand width constant. The decode stage uses the same package.
- One sub-module, alu_hilo, holds the HI/LO registers, the multiplier and the write-enable decode. It is instantiated only under ALU_MULDIV_EN.
- The result mux, adder/subtractor, comparators and barrel shifter live in the top module.

## Test plan
- ADD, A=0x7FFFFFFF, B=1 → result 0x80000000, overflow=1. ADDU with the same operands → overflow=0. SUB, A=5, B=5 → result 0, zero=1.
- SLT, A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0.
- Shifts with B=0x80000010 and A=0x00000024 (amount 4):
  - SRA → 0xF8000001.
  - SRL → 0x08000001.
  - SLL → 0x00000100.
- LUI, B=0x00001234 → 0x12340000. Undefined op 0x3F → result 0, zero=1.
- MULT, A=0xFFFFFFFE (−2), B=3, valid=1 at the edge:
  - MFHI in the same cycle returns the old value 0.
  - After the edge: MFHI → 0xFFFFFFFF, MFLO → 0xFFFFFFFA.
  - MULTU with the same operands then gives HI=0x00000002, LO=0xFFFFFFFA.
- MTLO, A=0xDEADBEEF, with valid=0 for 3 cycles → MFLO unchanged. Raise valid for one edge → MFLO=0xDEADBEEF. Assert rstn low mid-cycle → MFLO=0 immediately.
